alu_operand_stage: RTL and testbench

Operand-fetch stage directly upstream of the 16-bit ALU. Holds the register file, reads two source registers per accepted instruction, and presents registered A, B and Sel to the ALU inputs behind a valid/ready handshake. The ALU result returns through the write port. A single-entry output register decouples instruction issue from ALU consumption.

---
 rtl/alu_operand_stage.sv | 116 +++++++++++
 tb/tb_alu_operand_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: register file, two read ports, one-entry output register.
// Optional write-to-read forwarding on the same edge: define RF_BYPASS_EN.
module alu_operand_stage #(
  parameter  int Width = 16,
  parameter  int Depth = 16,
  localparam int AddrW = $clog2(Depth)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [AddrW-1:0] Raddr_A,
  input  logic [AddrW-1:0] Raddr_B,
  input  logic [2:0]       Sel_In,
  input  logic             W_En,
  input  logic [AddrW-1:0] W_Addr,
  input  logic [Width-1:0] W_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [Width-1:0] A,
  output logic [Width-1:0] B,
  output logic [2:0]       Sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [Width-1:0] rf [Depth];
  logic [Width-1:0] op_a;
  logic [Width-1:0] op_b;
  logic             wr_ok;
  logic             accept;
  logic             consume;

  // Index 0 is hardwired zero; indices past Depth do not exist.
  function automatic logic addr_ok(input logic [AddrW-1:0] a);
    logic [31:0] wide;
    wide = 32'(a);
    return (a != '0) && (wide < 32'(Depth));
  endfunction

  assign wr_ok     = W_En && addr_ok(W_Addr);
  assign Out_Valid = (state == FULL);
  assign In_Ready  = !Out_Valid || Out_Ready;
  assign accept    = In_Valid && In_Ready;
  assign consume   = Out_Valid && Out_Ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_ok) begin
      rf[W_Addr] <= W_Data;
    end
  end

  always_comb begin
    op_a = '0;
    if (addr_ok(Raddr_A)) begin
      op_a = rf[Raddr_A];
    end
`ifdef RF_BYPASS_EN
    if (wr_ok && (W_Addr == Raddr_A)) begin
      op_a = W_Data;
    end
`endif
  end

  always_comb begin
    op_b = '0;
    if (addr_ok(Raddr_B)) begin
      op_b = rf[Raddr_B];
    end
`ifdef RF_BYPASS_EN
    if (wr_ok && (W_Addr == Raddr_B)) begin
      op_b = W_Data;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY: if (accept) state_n = FULL;
      FULL:  if (consume && !accept) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  // Operands are sampled only at accept; later writes never reach them.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      A   <= '0;
      B   <= '0;
      Sel <= '0;
    end else if (accept) begin
      A   <= op_a;
      B   <= op_b;
      Sel <= Sel_In;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vectors plus a
// per-cycle comparison against a behavioural model.
module tb_alu_operand_stage;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          In_Valid;
  logic          In_Ready;
  logic [AW-1:0] Raddr_A;
  logic [AW-1:0] Raddr_B;
  logic [2:0]    Sel_In;
  logic          W_En;
  logic [AW-1:0] W_Addr;
  logic [W-1:0]  W_Data;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [2:0]    Sel;

  alu_operand_stage #(.Width(W), .Depth(D)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Raddr_A(Raddr_A), .Raddr_B(Raddr_B), .Sel_In(Sel_In),
    .W_En(W_En), .W_Addr(W_Addr), .W_Data(W_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .A(A), .B(B), .Sel(Sel)
  );

  always #5 Clk = ~Clk;

  int passed = 0;
  int total  = 0;
  bit cmp_en = 1'b0;
  logic [2:0] sel_log[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  // Behavioural model: array register file plus a single held operation.
  int   m_rf [D];
  bit   m_full;
  int   m_a;
  int   m_b;
  int   m_sel;

  function automatic int m_read(input int addr);
    int v;
    v = (addr == 0) ? 0 : m_rf[addr];
`ifdef RF_BYPASS_EN
    if (W_En && addr != 0 && int'(W_Addr) == addr) v = int'(W_Data);
`endif
    return v;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    bit acc;
    if (!Reset_n) begin
      foreach (m_rf[i]) m_rf[i] = 0;
      m_full = 0; m_a = 0; m_b = 0; m_sel = 0;
    end else begin
      acc = In_Valid && (!m_full || Out_Ready);
      if (acc) begin
        m_a   = m_read(int'(Raddr_A));
        m_b   = m_read(int'(Raddr_B));
        m_sel = int'(Sel_In);
      end
      if (W_En && W_Addr != 0) m_rf[W_Addr] = int'(W_Data);
      if (acc) m_full = 1;
      else if (Out_Ready) m_full = 0;
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("cyc_out_valid", 32'(Out_Valid), 32'(m_full));
      chk("cyc_in_ready", 32'(In_Ready), 32'(!m_full || Out_Ready));
      chk("cyc_a", 32'(A), m_a);
      chk("cyc_b", 32'(B), m_b);
      chk("cyc_sel", 32'(Sel), m_sel);
      if (Out_Valid && Out_Ready) sel_log.push_back(Sel);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    In_Valid = 0; W_En = 0; Out_Ready = 1;
    Raddr_A = 0; Raddr_B = 0; Sel_In = 0; W_Addr = 0; W_Data = 0;
  endtask

  initial begin
    Reset_n = 0;
    idle();
    repeat (3) tick();
    chk("rst_out_valid", 32'(Out_Valid), 32'd0);
    chk("rst_in_ready", 32'(In_Ready), 32'd1);
    chk("rst_a", 32'(A), 32'd0);
    Reset_n = 1;
    cmp_en = 1;
    tick();

    // write then read
    W_En = 1; W_Addr = 3; W_Data = 16'h00A5;
    tick();
    W_En = 0; In_Valid = 1; Raddr_A = 3; Raddr_B = 0; Sel_In = 3'b001;
    Out_Ready = 0;
    tick();
    chk("wr_rd_valid", 32'(Out_Valid), 32'd1);
    chk("wr_rd_a", 32'(A), 32'h00A5);
    chk("wr_rd_b", 32'(B), 32'h0);
    chk("wr_rd_sel", 32'(Sel), 32'd1);

    // backpressure: next op waits, write to reg3 must not reach A
    Raddr_B = 3; Sel_In = 3'b010;
    W_En = 1; W_Addr = 3; W_Data = 16'h1234;
    tick();
    W_En = 0;
    chk("bp_a_frozen", 32'(A), 32'h00A5);
    chk("bp_in_ready", 32'(In_Ready), 32'd0);
    chk("bp_sel_frozen", 32'(Sel), 32'd1);
    Out_Ready = 1;
    tick();
    chk("bp_nobubble_valid", 32'(Out_Valid), 32'd1);
    chk("bp_new_a", 32'(A), 32'h1234);
    chk("bp_new_b", 32'(B), 32'h1234);
    chk("bp_new_sel", 32'(Sel), 32'd2);
    In_Valid = 0;
    tick();
    chk("drain_valid", 32'(Out_Valid), 32'd0);
    chk("drain_a_hold", 32'(A), 32'h1234);

    // same-edge write/read hazard on reg5
    W_En = 1; W_Addr = 5; W_Data = 16'h0001;
    tick();
    W_Data = 16'hBEEF; In_Valid = 1; Raddr_A = 5; Raddr_B = 0; Sel_In = 3;
    tick();
    W_En = 0; In_Valid = 0;
`ifdef RF_BYPASS_EN
    chk("hazard_a", 32'(A), 32'hBEEF);
`else
    chk("hazard_a", 32'(A), 32'h0001);
`endif
    tick();
    In_Valid = 1; Raddr_A = 5; Raddr_B = 5; Sel_In = 4;
    tick();
    In_Valid = 0;
    chk("hazard_reg5_a", 32'(A), 32'hBEEF);
    chk("hazard_reg5_b", 32'(B), 32'hBEEF);

    // zero register, including same-edge write to index 0
    W_En = 1; W_Addr = 0; W_Data = 16'hFFFF;
    In_Valid = 1; Raddr_A = 0; Raddr_B = 0; Sel_In = 5;
    tick();
    W_En = 0;
    chk("zero_same_a", 32'(A), 32'h0);
    chk("zero_same_b", 32'(B), 32'h0);
    tick();
    In_Valid = 0;
    chk("zero_a", 32'(A), 32'h0);
    chk("zero_b", 32'(B), 32'h0);
    tick();

    // streaming 8 back-to-back operations
    sel_log.delete();
    for (int i = 0; i < 8; i++) begin
      In_Valid = 1; Raddr_A = AW'(i); Raddr_B = 3; Sel_In = 3'(i);
      tick();
      chk("stream_valid", 32'(Out_Valid), 32'd1);
    end
    In_Valid = 0;
    tick();
    tick();
    chk("stream_count", 32'(sel_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < sel_log.size()) chk("stream_sel", 32'(sel_log[i]), 32'(i));
    end

    // reset while FULL
    In_Valid = 1; Raddr_A = 3; Raddr_B = 5; Sel_In = 6; Out_Ready = 0;
    tick();
    In_Valid = 0;
    chk("pre_rst_valid", 32'(Out_Valid), 32'd1);
    #2;
    Reset_n = 0;
    #1;
    chk("midrst_valid", 32'(Out_Valid), 32'd0);
    chk("midrst_a", 32'(A), 32'd0);
    chk("midrst_b", 32'(B), 32'd0);
    chk("midrst_sel", 32'(Sel), 32'd0);
    chk("midrst_in_ready", 32'(In_Ready), 32'd1);
    tick();
    Reset_n = 1;
    tick();
    In_Valid = 1; Raddr_A = 3; Raddr_B = 5; Sel_In = 7; Out_Ready = 1;
    tick();
    In_Valid = 0;
    chk("postrst_a", 32'(A), 32'd0);
    chk("postrst_b", 32'(B), 32'd0);
    tick();
    tick();

    cmp_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
